// File: rtl/outstanding_tracker.sv
// Per-channel outstanding-request tracker: credit-limited request acceptance,
// response accounting with sticky underflow flags, and a drain/quiesce handshake.
module outstanding_tracker #(
    parameter int NUM_CH          = 4,
    parameter int CNT_W           = 8,
    parameter int MAX_OUTSTANDING = 32,
    parameter int TOT_W           = CNT_W + $clog2(NUM_CH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] rq_vld_in,
    output logic [NUM_CH-1:0] rq_rdy_out,
    input  logic [NUM_CH-1:0] rs_vld_in,
    input  logic              drain_req,
    output logic              drain_ack,
    input  logic              err_clr,
    output logic [NUM_CH-1:0] err_underflow,
    output logic [NUM_CH-1:0] ch_idle,
    output logic              done,
    output logic [TOT_W-1:0]  total_outstanding
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_DRAINED = 2'd2;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] count     [NUM_CH];
    logic [CNT_W-1:0] count_nxt [NUM_CH];
    logic [NUM_CH-1:0] acc;
    logic [NUM_CH-1:0] underflow;
    logic [NUM_CH-1:0] err_nxt;
    logic [TOT_W-1:0]  total_sum;

    // Ready depends only on registered state; a same-cycle response never frees a credit early.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            rq_rdy_out[c] = (count[c] < MAX_CNT) && (state == ST_RUN);
            ch_idle[c]    = (count[c] == '0);
        end
    end

    assign done      = &ch_idle;
    assign drain_ack = (state == ST_DRAINED);
    assign acc       = rq_vld_in & rq_rdy_out;

    always_comb begin
        total_sum = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            total_sum = total_sum + TOT_W'(count[c]);
        end
    end

    assign total_outstanding = total_sum;

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            count_nxt[c] = count[c];
            underflow[c] = 1'b0;
            if (acc[c] && !rs_vld_in[c]) begin
                count_nxt[c] = count[c] + 1'b1;
            end else if (!acc[c] && rs_vld_in[c]) begin
                if (count[c] != '0) begin
                    count_nxt[c] = count[c] - 1'b1;
                end else begin
                    underflow[c] = 1'b1;
                end
            end
        end
    end

    // A new underflow in the same cycle as a clear keeps its flag set.
    assign err_nxt = (err_underflow & ~{NUM_CH{err_clr}}) | underflow;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (drain_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drain_req) begin
                    state_nxt = ST_RUN;
                end else if (done) begin
                    state_nxt = ST_DRAINED;
                end
            end
            ST_DRAINED: begin
                if (!drain_req) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_RUN;
            err_underflow <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                count[c] <= '0;
            end
        end else begin
            state         <= state_nxt;
            err_underflow <= err_nxt;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                count[c] <= count_nxt[c];
            end
        end
    end

endmodule

// File: tb/tb_outstanding_tracker.sv
// Directed plus randomized bench for outstanding_tracker (2 channels, limit 4),
// checked every cycle against a behavioural credit/drain model.
module tb_outstanding_tracker;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int MAXO   = 4;
    localparam int TOT_W  = CNT_W + $clog2(NUM_CH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUM_CH-1:0] rq_vld_in = '0;
    logic [NUM_CH-1:0] rq_rdy_out;
    logic [NUM_CH-1:0] rs_vld_in = '0;
    logic              drain_req = 1'b0;
    logic              drain_ack;
    logic              err_clr = 1'b0;
    logic [NUM_CH-1:0] err_underflow;
    logic [NUM_CH-1:0] ch_idle;
    logic              done;
    logic [TOT_W-1:0]  total_outstanding;

    outstanding_tracker #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rq_vld_in(rq_vld_in),
        .rq_rdy_out(rq_rdy_out),
        .rs_vld_in(rs_vld_in),
        .drain_req(drain_req),
        .drain_ack(drain_ack),
        .err_clr(err_clr),
        .err_underflow(err_underflow),
        .ch_idle(ch_idle),
        .done(done),
        .total_outstanding(total_outstanding)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: outstanding count per channel, job phase (0 running, 1 draining, 2 drained), error flags.
    int m_cnt [NUM_CH];
    int m_phase;
    bit m_err [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready(input int c);
        return (m_cnt[c] < MAXO) && (m_phase == 0);
    endfunction

    task automatic model_step(input logic rn, input logic [1:0] v, input logic [1:0] r,
                              input logic d, input logic clr);
        bit all_zero;
        bit acc;
        if (!rn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[c] = 0;
                m_err[c] = 0;
            end
            m_phase = 0;
            return;
        end
        all_zero = 1;
        for (int c = 0; c < NUM_CH; c++) if (m_cnt[c] != 0) all_zero = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            acc = v[c] && m_ready(c);
            if (clr) m_err[c] = 0;
            if (acc && !r[c]) m_cnt[c]++;
            else if (!acc && r[c]) begin
                if (m_cnt[c] > 0) m_cnt[c]--;
                else m_err[c] = 1;
            end
        end
        case (m_phase)
            0: if (d) m_phase = 1;
            1: if (!d) m_phase = 0; else if (all_zero) m_phase = 2;
            default: if (!d) m_phase = 0;
        endcase
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] e_rdy, e_idle, e_err;
        int tot;
        tot = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            e_rdy[c]  = m_ready(c);
            e_idle[c] = (m_cnt[c] == 0);
            e_err[c]  = m_err[c];
            tot += m_cnt[c];
        end
        chk("rdy", 32'(rq_rdy_out), 32'(e_rdy));
        chk("idle", 32'(ch_idle), 32'(e_idle));
        chk("done", 32'(done), 32'(&e_idle));
        chk("total", 32'(total_outstanding), 32'(tot));
        chk("ack", 32'(drain_ack), 32'(m_phase == 2));
        chk("err", 32'(err_underflow), 32'(e_err));
    endtask

    task automatic tick(input logic rn, input logic [1:0] v, input logic [1:0] r,
                        input logic d, input logic clr);
        rst = rn;
        rq_vld_in = v;
        rs_vld_in = r;
        drain_req = d;
        err_clr = clr;
        @(posedge clk);
        #1;
        model_step(rn, v, r, d, clr);
        check_outputs();
    endtask

    initial begin
        logic d_hold;
        // 1. reset and basic counting
        tick(0, 2'b00, 2'b00, 0, 0);
        tick(0, 2'b00, 2'b00, 0, 0);
        chk("reset_rdy", 32'(rq_rdy_out), 32'h3);
        chk("reset_done", 32'(done), 32'h1);
        repeat (3) tick(1, 2'b01, 2'b00, 0, 0);
        chk("basic_total3", 32'(total_outstanding), 32'd3);
        chk("basic_done0", 32'(done), 32'h0);
        repeat (3) tick(1, 2'b00, 2'b01, 0, 0);
        chk("basic_done1", 32'(done), 32'h1);

        // 2. credit limit
        repeat (8) tick(1, 2'b01, 2'b00, 0, 0);
        chk("limit_total", 32'(total_outstanding), 32'd4);
        chk("limit_rdy", 32'(rq_rdy_out), 32'h2);
        tick(1, 2'b01, 2'b01, 0, 0);
        chk("limit_freed", 32'(rq_rdy_out), 32'h3);
        tick(1, 2'b01, 2'b00, 0, 0);
        chk("limit_refill", 32'(total_outstanding), 32'd4);
        repeat (4) tick(1, 2'b00, 2'b01, 0, 0);

        // 3. simultaneous request and response on ch1
        tick(1, 2'b10, 2'b10, 0, 0);
        chk("simul0_err", 32'(err_underflow), 32'h0);
        repeat (2) tick(1, 2'b10, 2'b00, 0, 0);
        tick(1, 2'b10, 2'b10, 0, 0);
        chk("simul2_total", 32'(total_outstanding), 32'd2);
        repeat (2) tick(1, 2'b00, 2'b10, 0, 0);

        // 4. underflow, clear, clear coincident with new underflow
        tick(1, 2'b00, 2'b10, 0, 0);
        chk("uf_set", 32'(err_underflow), 32'h2);
        tick(1, 2'b00, 2'b00, 0, 0);
        chk("uf_sticky", 32'(err_underflow), 32'h2);
        tick(1, 2'b00, 2'b00, 0, 1);
        chk("uf_clr", 32'(err_underflow), 32'h0);
        tick(1, 2'b00, 2'b10, 0, 1);
        chk("uf_set_wins", 32'(err_underflow), 32'h2);
        tick(1, 2'b00, 2'b00, 0, 1);

        // 5. drain with outstanding work, then drain at idle
        tick(1, 2'b11, 2'b00, 0, 0);
        repeat (2) tick(1, 2'b01, 2'b00, 0, 0);
        tick(1, 2'b00, 2'b00, 1, 0);
        chk("drain_rdy", 32'(rq_rdy_out), 32'h0);
        tick(1, 2'b11, 2'b11, 1, 0);
        repeat (2) tick(1, 2'b00, 2'b01, 1, 0);
        chk("drain_done", 32'(done), 32'h1);
        chk("drain_ack_wait", 32'(drain_ack), 32'h0);
        tick(1, 2'b00, 2'b00, 1, 0);
        chk("drain_ack", 32'(drain_ack), 32'h1);
        tick(1, 2'b00, 2'b00, 0, 0);
        chk("undrain_ack", 32'(drain_ack), 32'h0);
        chk("undrain_rdy", 32'(rq_rdy_out), 32'h3);
        tick(1, 2'b00, 2'b00, 1, 0);
        chk("idle_drain_1", 32'(drain_ack), 32'h0);
        tick(1, 2'b00, 2'b00, 1, 0);
        chk("idle_drain_2", 32'(drain_ack), 32'h1);
        tick(1, 2'b00, 2'b00, 0, 0);

        // 6. reset mid-drain
        repeat (2) tick(1, 2'b01, 2'b00, 0, 0);
        tick(1, 2'b00, 2'b00, 1, 0);
        tick(0, 2'b00, 2'b00, 0, 0);
        chk("rstmid_rdy", 32'(rq_rdy_out), 32'h3);
        chk("rstmid_total", 32'(total_outstanding), 32'd0);
        tick(1, 2'b00, 2'b01, 0, 0);
        chk("rstmid_stray", 32'(err_underflow), 32'h1);

        // randomized traffic
        d_hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic rn;
            logic [1:0] v, r;
            logic clr;
            if ($urandom_range(0, 39) == 0) d_hold = ~d_hold;
            rn  = ($urandom_range(0, 299) != 0);
            v   = 2'($urandom);
            r   = 2'($urandom) & 2'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            tick(rn, v, r, d_hold, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/outstanding_tracker.md
Name: outstanding_tracker

Overview:
Per-channel outstanding-request tracker with credit limiting and a drain handshake. It is the multi-channel, bounded successor of the single request/response counter used by the probe engine. It counts accepted memory requests against returned responses on NUM_CH independent channels and throttles each channel at MAX_OUTSTANDING. It also offers a drain mode for end-of-job quiescence and flags protocol errors (responses without a matching request).

Parameters:
NUM_CH, 4, number of independent request/response channels (>=1)
CNT_W, 8, width of each per-channel outstanding counter
MAX_OUTSTANDING, 32, per-channel credit limit; must satisfy 1 <= MAX_OUTSTANDING <= 2^CNT_W-1
TOT_W, CNT_W+$clog2(NUM_CH)+1, width of total_outstanding

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
rq_vld_in  in  NUM_CH  bit c: channel c presents a request this cycle
rq_rdy_out  out  NUM_CH  bit c: channel c may issue; request accepted when rq_vld_in[c] & rq_rdy_out[c]
rs_vld_in  in  NUM_CH  bit c: one response returned on channel c this cycle
drain_req  in  1  level; 1 requests drain (block new requests, wait for zero outstanding)
drain_ack  out  1  level; 1 when drained and drain_req still high
err_clr  in  1  pulse; clears sticky error flags
err_underflow  out  NUM_CH  sticky: response seen on channel c while its count was 0 with no same-cycle accept
ch_idle  out  NUM_CH  bit c: count[c]==0
done  out  1  all channel counts zero (AND of ch_idle)
total_outstanding  out  TOT_W  sum of all channel counts

Behaviour:
- Reset (rst==0 at clock edge): all count[c]=0, FSM=RUN, err_underflow=0. Immediately after reset: rq_rdy_out=all 1, ch_idle=all 1, done=1, drain_ack=0, total_outstanding=0.
- Accept: acc[c] = rq_vld_in[c] & rq_rdy_out[c]. rq_vld_in while rq_rdy_out=0 is ignored and not counted.
- Counter update, per channel each cycle:
  - acc=1, rs=0: count+1.
  - acc=0, rs=1, count>0: count-1.
  - acc=1, rs=1: unchanged. This holds even at count 0, with no error.
  - acc=0, rs=1, count==0: count stays 0 and err_underflow[c] is set.
- Counts never wrap. Increments are impossible at MAX_OUTSTANDING because rq_rdy_out is low there.
- rq_rdy_out[c] = (count[c] < MAX_OUTSTANDING) & (FSM==RUN).
  - Combinational from registered state only; no same-cycle response forwarding.
  - At count==MAX with rs_vld_in[c]=1, rdy stays 0 that cycle and rises the next cycle.
- Status outputs ch_idle, done and total_outstanding are combinational from registered counts. They reflect updates one cycle after the accepting or returning edge, i.e. zero-latency relative to register state.
- FSM states:
  - RUN: -> DRAIN when drain_req=1.
  - DRAIN: all rq_rdy_out=0; responses still decrement counts. -> DRAINED when done=1 (registered counts all zero). If drain_req drops before that, -> RUN.
  - DRAINED: drain_ack=1, rq_rdy_out=0. -> RUN when drain_req=0. drain_ack deasserts in the same cycle the state leaves DRAINED.
- drain_req asserted while already idle: RUN -> DRAIN (1 cycle) -> DRAINED. drain_ack rises 2 cycles after drain_req.
- Responses arriving in DRAINED (protocol violation) hit count 0 and set err_underflow; FSM stays DRAINED.
- Errors:
  - err_clr=1 clears all err_underflow bits.
  - If a new underflow occurs in the same cycle as err_clr, set wins for that channel.
- Reset mid-operation (any state, any counts): returns to reset values at that edge; in-flight responses after reset are counted as underflows.
- Channels are fully independent; any combination of bits on rq_vld_in/rs_vld_in in one cycle is legal.

Test Plan:
All scenarios use NUM_CH=2, CNT_W=8, MAX_OUTSTANDING=4 unless stated.
1. Reset and basic counting: release rst; 3 accepted requests on ch0, then 3 responses -> count0 goes 1,2,3,2,1,0; done=0 from the cycle after the first accept until the cycle after the last response; total_outstanding tracks; err_underflow=0.
2. Credit limit: hold rq_vld_in[0]=1 for 8 cycles, no responses -> exactly 4 accepts, rq_rdy_out[0]=0 from cycle 5. Then one response -> rdy returns the following cycle and one more accept occurs, count stays 4. ch1 remains rdy throughout.
3. Simultaneous events: on ch1 at count 0, apply rq and rs in the same cycle -> count stays 0, no error. At count 2, same stimulus -> count stays 2.
4. Underflow: rs_vld_in[1]=1 at count 0 with no request -> count1=0, err_underflow=2'b10 sticky. err_clr pulse -> 2'b00. err_clr coincident with a new underflow -> flag remains 1.
5. Drain: with count0=3 and count1=1, raise drain_req -> rq_rdy_out=00 next cycle. Return the 4 responses -> drain_ack=1 one cycle after done rises. Drop drain_req -> drain_ack=0 and rq_rdy_out=11 next cycle. Also: drain_req at idle -> drain_ack after exactly 2 cycles.
6. Reset mid-drain: in DRAIN with count0=2, pull rst low one cycle -> counts 0, FSM RUN, rq_rdy_out=11, drain_ack=0, errors 0. A subsequent stray response on ch0 sets err_underflow[0].
